// File: rtl/placement_registry_pkg.sv
// rtl/placement_registry_pkg.sv - shared parameters and types for nest/patch placement
// Contents: table sizing, coordinate widths, separation threshold, point_t, placement_state_t.
package placement_registry_pkg;

   localparam int NEST_num       = 4;
   localparam int SUGARPATCH_num = 8;
   localparam int X_bits         = 8;
   localparam int Y_bits         = 7;
   localparam int MIN_SEP        = 16;
   localparam int TOTAL          = NEST_num + SUGARPATCH_num;

   localparam int NEST_ID_W  = $clog2(NEST_num);
   localparam int PATCH_ID_W = $clog2(SUGARPATCH_num);
   localparam int NEST_CNT_W = $clog2(NEST_num + 1);
   localparam int PATCH_CNT_W = $clog2(SUGARPATCH_num + 1);
   localparam int IDX_W      = $clog2(TOTAL);

   typedef struct packed {
      logic [X_bits-1:0] x;
      logic [Y_bits-1:0] y;
   } point_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } placement_state_t;

endpackage

// File: rtl/placement_registry_sep_compare.sv
// rtl/placement_registry_sep_compare.sv - combinational Chebyshev proximity test
// Ports:
//   a_i, b_i  in  point_t  the two points
//   valid_i   in  1        b_i is a live entry; an invalid entry never hits
//   hit_o     out 1        both axis distances below MIN_SEP
module sep_compare
   import placement_registry_pkg::*;
(
   input  point_t a_i,
   input  point_t b_i,
   input  logic   valid_i,
   output logic   hit_o
);

   // Differences are taken one bit wider and signed so the magnitude never wraps.
   logic signed [X_bits:0] dx_s;
   logic signed [Y_bits:0] dy_s;
   logic        [X_bits:0] dx_abs;
   logic        [Y_bits:0] dy_abs;

   always_comb begin
      dx_s   = $signed({1'b0, a_i.x}) - $signed({1'b0, b_i.x});
      dy_s   = $signed({1'b0, a_i.y}) - $signed({1'b0, b_i.y});
      dx_abs = dx_s[X_bits] ? $unsigned(-dx_s) : $unsigned(dx_s);
      dy_abs = dy_s[Y_bits] ? $unsigned(-dy_s) : $unsigned(dy_s);
      hit_o  = valid_i
               && (dx_abs < (X_bits+1)'(MIN_SEP))
               && (dy_abs < (Y_bits+1)'(MIN_SEP));
   end

endmodule

// File: rtl/placement_registry.sv
// rtl/placement_registry.sv - nest/sugar-patch coordinate table with sequential overlap scan
// Ports:
//   setup_clk, RESET_SIM (async, active high), clear (sync table clear)
//   cand_x/cand_y, check_req -> check_busy, check_done (1-cycle), collision
//   commit_nest/nest_id, commit_patch/patch_id -> commit_err (1-cycle)
//   nests_X/nests_Y, patches_X/patches_Y, nest_count, patch_count
module placement_registry
   import placement_registry_pkg::*;
(
   input  logic                                      setup_clk,
   input  logic                                      RESET_SIM,
   input  logic                                      clear,
   input  logic [X_bits-1:0]                         cand_x,
   input  logic [Y_bits-1:0]                         cand_y,
   input  logic                                      check_req,
   output logic                                      check_busy,
   output logic                                      check_done,
   output logic                                      collision,
   input  logic                                      commit_nest,
   input  logic [NEST_ID_W-1:0]                      nest_id,
   input  logic                                      commit_patch,
   input  logic [PATCH_ID_W-1:0]                     patch_id,
   output logic                                      commit_err,
   output logic [NEST_num-1:0][X_bits-1:0]           nests_X,
   output logic [NEST_num-1:0][Y_bits-1:0]           nests_Y,
   output logic [SUGARPATCH_num-1:0][X_bits-1:0]     patches_X,
   output logic [SUGARPATCH_num-1:0][Y_bits-1:0]     patches_Y,
   output logic [NEST_CNT_W-1:0]                     nest_count,
   output logic [PATCH_CNT_W-1:0]                    patch_count
);

   // Entries 0..NEST_num-1 are nests, the rest are patches.
   point_t                 ent_q [TOTAL];
   logic [TOTAL-1:0]       valid_q;
   point_t                 cand_q;
   logic [IDX_W-1:0]       idx_q;
   placement_state_t       state_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   collision_q;
   logic                   commit_err_q;
   logic [NEST_CNT_W-1:0]  nest_count_q;
   logic [PATCH_CNT_W-1:0] patch_count_q;

   logic                   in_idle;
   logic                   nest_in_range;
   logic                   patch_in_range;
   logic                   nest_wr;
   logic                   patch_wr;
   logic                   commit_err_d;
   logic [IDX_W-1:0]       patch_idx;
   logic                   hit;

   // The range checks are zero-extended so they stay meaningful for non power-of-two tables.
   always_comb begin
      in_idle        = (state_q == IDLE);
      nest_in_range  = ({1'b0, nest_id}  < (NEST_ID_W+1)'(NEST_num));
      patch_in_range = ({1'b0, patch_id} < (PATCH_ID_W+1)'(SUGARPATCH_num));
      nest_wr        = commit_nest  && nest_in_range  && in_idle;
      patch_wr       = commit_patch && patch_in_range && in_idle;
      patch_idx      = IDX_W'(NEST_num) + IDX_W'(patch_id);
      // A clear swallows any same-cycle commit silently.
      commit_err_d   = !clear
                       && ((commit_nest  && (!in_idle || !nest_in_range))
                        || (commit_patch && (!in_idle || !patch_in_range)));
   end

   sep_compare u_sep_compare (
      .a_i     (cand_q),
      .b_i     (ent_q[idx_q]),
      .valid_i (valid_q[idx_q]),
      .hit_o   (hit)
   );

   always_ff @(posedge setup_clk or posedge RESET_SIM) begin
      if (RESET_SIM) begin
         for (int i = 0; i < TOTAL; i++) begin
            ent_q[i] <= '0;
         end
         valid_q       <= '0;
         cand_q        <= '0;
         idx_q         <= '0;
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         collision_q   <= 1'b0;
         commit_err_q  <= 1'b0;
         nest_count_q  <= '0;
         patch_count_q <= '0;
      end else begin
         commit_err_q <= commit_err_d;
         done_q       <= 1'b0;
         if (clear) begin
            valid_q       <= '0;
            nest_count_q  <= '0;
            patch_count_q <= '0;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            if (!in_idle) begin
               collision_q <= 1'b0;
            end
         end else begin
            if (nest_wr) begin
               ent_q[nest_id]   <= {cand_x, cand_y};
               valid_q[nest_id] <= 1'b1;
               if (!valid_q[nest_id]) begin
                  nest_count_q <= nest_count_q + NEST_CNT_W'(1);
               end
            end
            if (patch_wr) begin
               ent_q[patch_idx]   <= {cand_x, cand_y};
               valid_q[patch_idx] <= 1'b1;
               if (!valid_q[patch_idx]) begin
                  patch_count_q <= patch_count_q + PATCH_CNT_W'(1);
               end
            end
            case (state_q)
               IDLE: begin
                  if (check_req) begin
                     cand_q      <= {cand_x, cand_y};
                     idx_q       <= '0;
                     collision_q <= 1'b0;
                     state_q     <= SCAN;
                     busy_q      <= 1'b1;
                  end
               end
               SCAN: begin
                  if (hit) begin
                     collision_q <= 1'b1;
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                  end else if (idx_q == IDX_W'(TOTAL-1)) begin
                     collision_q <= 1'b0;
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NEST_num; i++) begin
         nests_X[i] = ent_q[i].x;
         nests_Y[i] = ent_q[i].y;
      end
      for (int i = 0; i < SUGARPATCH_num; i++) begin
         patches_X[i] = ent_q[NEST_num+i].x;
         patches_Y[i] = ent_q[NEST_num+i].y;
      end
   end

   assign check_busy  = busy_q;
   assign check_done  = done_q;
   assign collision   = collision_q;
   assign commit_err  = commit_err_q;
   assign nest_count  = nest_count_q;
   assign patch_count = patch_count_q;

endmodule
